// File: rtl/sort.sv
// Eight-key sorter: 19-comparator odd-even merge network feeding one output register stage.
// Define SORT_DESCENDING_EN to emit keys largest-first instead of smallest-first.
module sort #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic [WIDTH-1:0] n3,
  input  logic [WIDTH-1:0] n4,
  input  logic [WIDTH-1:0] n5,
  input  logic [WIDTH-1:0] n6,
  input  logic [WIDTH-1:0] n7,
  input  logic [WIDTH-1:0] n8,
  output logic             out_valid,
  output logic [WIDTH-1:0] first,
  output logic [WIDTH-1:0] second,
  output logic [WIDTH-1:0] third,
  output logic [WIDTH-1:0] fourth,
  output logic [WIDTH-1:0] fifth,
  output logic [WIDTH-1:0] sixth,
  output logic [WIDTH-1:0] seventh,
  output logic [WIDTH-1:0] eighth
);

  localparam int NCMP = 19;

  // Comparator pairs listed in dependency order; pairs within a layer are independent.
  localparam logic [2:0] LO [NCMP] = '{
    3'd0, 3'd2, 3'd4, 3'd6,
    3'd0, 3'd1, 3'd4, 3'd5,
    3'd1, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3,
    3'd2, 3'd3,
    3'd1, 3'd3, 3'd5
  };
  localparam logic [2:0] HI [NCMP] = '{
    3'd1, 3'd3, 3'd5, 3'd7,
    3'd2, 3'd3, 3'd6, 3'd7,
    3'd2, 3'd6,
    3'd4, 3'd5, 3'd6, 3'd7,
    3'd4, 3'd5,
    3'd2, 3'd4, 3'd6
  };

  logic [WIDTH-1:0] keys_d [8];
  logic [WIDTH-1:0] keys_q [8];
  logic             valid_q;

  always_comb begin
    logic [WIDTH-1:0] tmp;
    logic             swap;
    tmp    = '0;
    swap   = 1'b0;
    keys_d = '{n1, n2, n3, n4, n5, n6, n7, n8};
    for (int c = 0; c < NCMP; c++) begin
`ifdef SORT_DESCENDING_EN
      swap = keys_d[LO[c]] < keys_d[HI[c]];
`else
      swap = keys_d[LO[c]] > keys_d[HI[c]];
`endif
      if (swap) begin
        tmp            = keys_d[LO[c]];
        keys_d[LO[c]]  = keys_d[HI[c]];
        keys_d[HI[c]]  = tmp;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          keys_q[gi] <= '0;
        end else if (in_valid) begin
          keys_q[gi] <= keys_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
    end
  end

  assign out_valid = valid_q;
  assign first     = keys_q[0];
  assign second    = keys_q[1];
  assign third     = keys_q[2];
  assign fourth    = keys_q[3];
  assign fifth     = keys_q[4];
  assign sixth     = keys_q[5];
  assign seventh   = keys_q[6];
  assign eighth    = keys_q[7];

endmodule

// File: tb/tb_sort.sv
// Directed and random checks for the eight-key sorter (WIDTH = 8).
module tb_sort;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] nv [8];
  logic       out_valid;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;

  int total;
  int passed;

  sort #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .n1(nv[0]), .n2(nv[1]), .n3(nv[2]), .n4(nv[3]),
    .n5(nv[4]), .n6(nv[5]), .n7(nv[6]), .n8(nv[7]),
    .out_valid(out_valid),
    .first(o1), .second(o2), .third(o3), .fourth(o4),
    .fifth(o5), .sixth(o6), .seventh(o7), .eighth(o8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed vector: key k lives in bits [8k+7:8k]; k=0 is n1 / first.
  function automatic logic [63:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [63:0] r;
    r = {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return r;
  endfunction

  function automatic logic [63:0] rev(input logic [63:0] v);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = v[8*(7-k) +: 8];
    return r;
  endfunction

  // Expected output for a hand-computed ascending list in the current build.
  function automatic logic [63:0] order(input logic [63:0] asc);
`ifdef SORT_DESCENDING_EN
    return rev(asc);
`else
    return asc;
`endif
  endfunction

  function automatic logic [63:0] ref_sort(input logic [63:0] v);
    int a [8];
    int t;
    logic [63:0] r;
    for (int k = 0; k < 8; k++) a[k] = int'(v[8*k +: 8]);
    for (int i = 1; i < 8; i++) begin
      t = a[i];
      for (int j = i - 1; j >= 0; j--) begin
        if (a[j] > t) begin
          a[j+1] = a[j];
          a[j]   = t;
        end
      end
    end
    for (int k = 0; k < 8; k++) r[8*k +: 8] = a[k][7:0];
    return order(r);
  endfunction

  function automatic logic [63:0] got();
    return {o8, o7, o6, o5, o4, o3, o2, o1};
  endfunction

  task automatic set_in(input logic [63:0] v, input logic vld);
    for (int k = 0; k < 8; k++) nv[k] = v[8*k +: 8];
    in_valid = vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] exp_d, input logic exp_v);
    logic [63:0] g;
    g = got();
    total++;
    assert (g === exp_d) passed++;
    else $error("FAIL %s data observed=%h expected=%h", tag, g, exp_d);
    total++;
    assert (out_valid === exp_v) passed++;
    else $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_v);
  endtask

  initial begin
    logic [63:0] r1, v;
    total    = 0;
    passed   = 0;
    rst      = 1'b1;
    set_in(64'h0, 1'b0);

    #2;
    chk("reset_async", 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    set_in(pk(5, 12, 255, 1, 0, 12, 19, 68), 1'b1);
    step();
    $display("vec mixed: out=%h valid=%b", got(), out_valid);
    chk("mixed", order(pk(0, 1, 5, 12, 12, 19, 68, 255)), 1'b1);

    set_in({8{8'hFF}}, 1'b1);
    step();
    $display("vec all255: out=%h valid=%b", got(), out_valid);
    chk("all_255", {8{8'hFF}}, 1'b1);
    set_in(64'h0, 1'b1);
    step();
    $display("vec all0: out=%h valid=%b", got(), out_valid);
    chk("all_0", 64'h0, 1'b1);

    set_in(pk(8, 7, 6, 5, 4, 3, 2, 1), 1'b1);
    step();
    $display("vec rev: out=%h valid=%b", got(), out_valid);
    chk("b2b_1", order(pk(1, 2, 3, 4, 5, 6, 7, 8)), 1'b1);
    set_in(pk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1);
    step();
    $display("vec fwd: out=%h valid=%b", got(), out_valid);
    chk("b2b_2", order(pk(1, 2, 3, 4, 5, 6, 7, 8)), 1'b1);

    set_in(pk(200, 0, 255, 3, 3, 90, 0, 17), 1'b1);
    step();
    r1 = order(pk(0, 0, 3, 3, 17, 90, 200, 255));
    $display("vec dup: out=%h valid=%b", got(), out_valid);
    chk("dups_bounds", r1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(pk(9, 9, 9, 9, 1, 1, 1, 1), 1'b0);
      step();
      $display("idle %0d: out=%h valid=%b", i, got(), out_valid);
      chk("hold", r1, 1'b0);
    end

    set_in(pk(40, 30, 20, 10, 70, 60, 50, 0), 1'b1);
    step();
    chk("pre_rst", order(pk(0, 10, 20, 30, 40, 50, 60, 70)), 1'b1);
    set_in(pk(1, 1, 1, 1, 2, 2, 2, 2), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    $display("mid reset: out=%h valid=%b", got(), out_valid);
    chk("mid_rst", 64'h0, 1'b0);
    #1;
    rst = 1'b0;
    set_in(pk(77, 66, 255, 0, 128, 127, 1, 254), 1'b1);
    step();
    $display("post reset: out=%h valid=%b", got(), out_valid);
    chk("post_rst", order(pk(0, 1, 66, 77, 127, 128, 254, 255)), 1'b1);

    for (int i = 0; i < 10000; i++) begin
      v = {$urandom(), $urandom()};
      if (i % 97 == 0) v[15:0] = 16'h00FF;
      set_in(v, 1'b1);
      step();
      if (i % 1000 == 0) $display("random %0d: in=%h out=%h", i, v, got());
      chk("random", ref_sort(v), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sort.md
SORT -- requirements
Module: sort

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of each key.
REQ-002 SHALL have port clk, input, 1 bit; single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit; qualifies n1..n8 on the current rising edge.
REQ-005 SHALL have ports n1, n2, n3, n4, n5, n6, n7, n8, each input, WIDTH bits; unsigned keys to sort.
REQ-006 SHALL have port out_valid, output, 1 bit; asserted when first..eighth hold a new sorted result.
REQ-007 SHALL have ports first, second, third, fourth, fifth, sixth, seventh, eighth, each output, WIDTH bits; sorted keys in rank order.

Function
REQ-008 SHALL treat all keys as unsigned integers.
REQ-009 SHALL order outputs ascending by default: first = minimum, eighth = maximum, first <= second <= ... <= eighth.
REQ-010 SHALL output a permutation of the inputs; duplicate keys each appear once per occurrence, with no loss and no merging.
REQ-011 SHALL sort with a combinational compare-exchange network of 8 inputs (odd-even merge, 19 comparators), followed by one output register stage.
REQ-012 SHALL, on a rising clk edge with in_valid=1, load the sorted result of n1..n8 into first..eighth and set out_valid=1; latency is exactly 1 cycle.
REQ-013 SHALL, on a rising clk edge with in_valid=0, hold first..eighth unchanged and set out_valid=0.
REQ-014 SHALL accept a new input set every cycle (throughput 1 per clock) with no backpressure.
REQ-015 SHALL produce correct results at boundary keys 0 and 2^WIDTH-1 and when all eight keys are equal.

Reset
REQ-016 SHALL, while rst=1, immediately force out_valid=0 and all of first..eighth to 0, independent of clk.
REQ-017 SHALL, if rst asserts mid-stream, discard the in-flight result; the first clk edge after rst deasserts with in_valid=1 produces a valid result.

Configuration
REQ-018 SHALL support macro SORT_DESCENDING_EN: when defined, outputs are in descending order (first = maximum, eighth = minimum); when undefined, outputs are ascending per REQ-009; latency, reset and handshake are identical in both builds.

Verification
REQ-019 SHALL pass this test: n1..n8 = 5,12,255,1,0,12,19,68 with in_valid=1 for one edge -> next cycle first..eighth = 0,1,5,12,12,19,68,255 and out_valid=1; the descending build gives 255,68,19,12,12,5,1,0.
REQ-020 SHALL pass this test: all inputs = 255, then all inputs = 0 -> all outputs 255 for one cycle, then all outputs 0.
REQ-021 SHALL pass this test: inputs 8,7,6,5,4,3,2,1 then 1..8 on back-to-back cycles -> two consecutive valid results, both 1..8, with out_valid high for 2 cycles.
REQ-022 SHALL pass this test: a valid result, then in_valid=0 for 3 cycles -> outputs hold and out_valid=0.
REQ-023 SHALL pass this test: rst pulsed between clock edges during streaming -> outputs and out_valid go to 0 immediately, and the next valid input is sorted correctly.
REQ-024 SHALL pass this test: 10k random input vectors -> each result matches a reference sort.
